// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: sequencer states, UART register map and status bit positions.
package uart_sched_pkg;
    localparam logic [2:0] BOOT = 3'd0, DIVLO = 3'd1, DIVHI = 3'd2, IDLE = 3'd3;
    localparam logic [2:0] STAT = 3'd4, RXRD = 3'd5, TXACK = 3'd6, TX = 3'd7;
    localparam logic [3:0] UART_A_RX = 4'd0, UART_A_TX = 4'd1, UART_A_STAT = 4'd2;
    localparam logic [3:0] UART_A_DIVLO = 4'd4, UART_A_DIVHI = 4'd5;
    localparam int ST_RXINT = 1, ST_TXINT = 0;
endpackage

// File: rtl/uart_sched_rr_arbiter.sv
// rr_arbiter: cyclic first-valid-after-pointer search, overridden by a message lock.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    input  logic            lock,
    input  logic [W-1:0]    lock_id,
    output logic [NREQ-1:0] grant,
    output logic [W-1:0]    idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // descending scan so the nearest index after ptr is written last
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = W'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
        if (lock) begin
            idx = lock_id;
            any = req[lock_id];
        end
        grant = '0;
        grant[idx] = any;
    end
endmodule

// File: rtl/uart_sched.sv
// uart_sched: boots the UART divisor, arbitrates transmit requesters and polls
// the UART status to service receive and transmit-done interrupts.
module uart_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CLOCK = 20000000,
    parameter int BAUD  = 115200,
    parameter int DIV   = CLOCK / BAUD / 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic                    tx_busy,
    output logic [3:0]              io_addr,
    output logic [7:0]              io_wdata,
    output logic                    io_write,
    output logic                    io_read,
    input  logic [7:0]              io_rdata,
    input  logic                    uart_interrupt
);
    localparam int W = $clog2(NREQ);
    localparam logic [11:0] D = 12'(DIV);

    logic [2:0] state, nxt;
    logic [W-1:0] rr, g, lock_id, arb_idx;
    logic [NREQ-1:0] g_oh, arb_oh;
    logic lock, arb_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(req_valid), .ptr(rr), .lock(lock), .lock_id(lock_id),
        .grant(arb_oh), .idx(arb_idx), .any(arb_any)
    );

    always_comb begin
        nxt = state == BOOT  ? DIVLO :
              state == DIVLO ? DIVHI :
              state == DIVHI ? IDLE  :
              state == IDLE  ? (uart_interrupt ? STAT : (!tx_busy && arb_any) ? TX : IDLE) :
              state == STAT  ? (io_rdata[ST_RXINT] ? RXRD : io_rdata[ST_TXINT] ? TXACK : IDLE) :
              IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            rr       <= W'(NREQ - 1);
            g        <= '0;
            g_oh     <= '0;
            lock     <= 1'b0;
            lock_id  <= '0;
            grant_id <= '0;
            tx_busy  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= nxt;
            rx_valid <= state == RXRD;
            if (state == RXRD) rx_data <= io_rdata;
            if (state == IDLE) begin
                g    <= arb_idx;
                g_oh <= arb_oh;
            end
            if (state == TXACK) tx_busy <= 1'b0;
            if (state == TX) begin
                tx_busy  <= 1'b1;
                grant_id <= g;
                rr       <= g;
                lock     <= ~req_last[g];
                lock_id  <= g;
            end
        end
    end

    always_comb begin
        io_write  = state == DIVLO || state == DIVHI || state == TXACK || state == TX;
        io_read   = state == STAT || state == RXRD;
        io_addr   = state == DIVLO ? UART_A_DIVLO :
                    state == DIVHI ? UART_A_DIVHI :
                    (state == STAT || state == TXACK) ? UART_A_STAT :
                    state == TX ? UART_A_TX : UART_A_RX;
        io_wdata  = state == DIVLO ? D[7:0] :
                    state == DIVHI ? {4'b0, D[11:8]} :
                    state == TXACK ? 8'h01 :
                    state == TX ? req_data[{g, 3'b000} +: 8] : 8'h00;
        req_ready = state == TX ? g_oh : '0;
    end
endmodule

// File: tb/tb_uart_sched.sv
// tb_uart_sched: scoreboard bench with a small UART register model and queued requesters.
module tb_uart_sched;
    localparam int N = 4;

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic [3:0] r;
    } ev_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [1:0] grant_id;
    logic [7:0] rx_data, io_wdata, io_rdata;
    logic rx_valid, tx_busy, io_write, io_read, uart_interrupt;
    logic [3:0] io_addr;

    logic [1:0] st;
    logic [7:0] rxb;
    int txcnt;
    logic auto_tx = 1'b1, set_rx = 1'b0, set_tx = 1'b0;
    logic [7:0] rx_byte = '0;

    ev_t exq[$];
    logic [7:0] rxq[$];
    logic [8:0] rq[N][$];
    int n_chk = 0, n_fail = 0;

    uart_sched #(.NREQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_write(io_write),
        .io_read(io_read), .io_rdata(io_rdata), .uart_interrupt(uart_interrupt)
    );

    always #5 clk = ~clk;

    assign io_rdata = io_addr == 4'd2 ? {6'b0, st} : io_addr == 4'd0 ? rxb : 8'h00;
    assign uart_interrupt = |st;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= '0;
            txcnt <= 0;
            rxb <= '0;
        end else begin
            if (io_write && io_addr == 4'd1) txcnt <= auto_tx ? 6 : 0;
            else if (txcnt > 0) txcnt <= txcnt - 1;
            if (txcnt == 1 || set_tx) st[0] <= 1'b1;
            if (io_write && io_addr == 4'd2 && io_wdata[0]) st[0] <= 1'b0;
            if (io_read && io_addr == 4'd0) st[1] <= 1'b0;
            if (set_rx) begin
                st[1] <= 1'b1;
                rxb <= rx_byte;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, ex);
        end
    endtask

    function automatic ev_t mk(input logic w, input logic [3:0] a, input logic [7:0] d, input logic [3:0] r);
        return ev_t'({w, a, d, r});
    endfunction

    task automatic expect_tx(input int id, input logic [7:0] d);
        exq.push_back(mk(1'b1, 4'd1, d, 4'(1 << id)));
        exq.push_back(mk(1'b0, 4'd2, 8'h00, 4'h0));
        exq.push_back(mk(1'b1, 4'd2, 8'h01, 4'h0));
    endtask

    task automatic expect_boot();
        exq.push_back(mk(1'b1, 4'd4, 8'h2B, 4'h0));
        exq.push_back(mk(1'b1, 4'd5, 8'h00, 4'h0));
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while ((exq.size() != 0 || rxq.size() != 0) && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk(nm, exq.size() + rxq.size(), 0);
        repeat (10) @(posedge clk);
    endtask

    task automatic pulse(input logic rx, input logic tx, input logic [7:0] b);
        @(posedge clk);
        #1;
        set_rx = rx;
        set_tx = tx;
        rx_byte = b;
        @(posedge clk);
        #1;
        set_rx = 1'b0;
        set_tx = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (io_write || io_read) begin
                if (exq.size() == 0) chk("unexpected_bus", {15'b0, io_write, io_addr, io_wdata, req_ready}, 0);
                else begin
                    e = exq.pop_front();
                    chk("bus_op", {io_write, io_addr, io_write ? io_wdata : 8'h00, req_ready}, e);
                end
            end else if (req_ready != '0) chk("stray_ready", req_ready, 0);
            if (rx_valid) begin
                if (rxq.size() == 0) chk("unexpected_rx", {1'b1, rx_data}, 0);
                else chk("rx_data", rx_data, rxq.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        forever begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (r[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                req_valid[i] = rq[i].size() != 0;
                {req_last[i], req_data[8*i +: 8]} = rq[i].size() != 0 ? rq[i][0] : 9'h0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_write", io_write, 0);
        chk("rst_io_read", io_read, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_grant_id", grant_id, 0);

        expect_boot();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("boot_quiet", {io_write, io_read}, 0);
        @(posedge clk);
        #1;
        chk("divlo_cycle", {io_write, io_addr}, {1'b1, 4'd4});
        drain("boot");

        expect_tx(0, 8'h55);
        rq[0].push_back({1'b1, 8'h55});
        c = 0;
        while (!tx_busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("tx_busy_rise", tx_busy, 1);
        drain("single");
        chk("tx_busy_fall", tx_busy, 0);
        chk("grant_single", grant_id, 0);

        expect_tx(1, 8'h11);
        expect_tx(2, 8'h21);
        expect_tx(1, 8'h12);
        expect_tx(2, 8'h22);
        rq[1].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        rq[2].push_back({1'b1, 8'h21});
        rq[2].push_back({1'b1, 8'h22});
        drain("round_robin");
        chk("grant_rr", grant_id, 2);

        expect_tx(0, 8'hA0);
        expect_tx(0, 8'hA1);
        expect_tx(0, 8'hA2);
        expect_tx(1, 8'hB0);
        rq[0].push_back({1'b0, 8'hA0});
        rq[0].push_back({1'b0, 8'hA1});
        rq[0].push_back({1'b1, 8'hA2});
        rq[1].push_back({1'b1, 8'hB0});
        drain("lock");
        chk("grant_lock", grant_id, 1);

        exq.push_back(mk(1'b0, 4'd2, 8'h00, 4'h0));
        exq.push_back(mk(1'b0, 4'd0, 8'h00, 4'h0));
        rxq.push_back(8'hC3);
        pulse(1'b1, 1'b0, 8'hC3);
        drain("rx");

        auto_tx = 1'b0;
        exq.push_back(mk(1'b1, 4'd1, 8'h3C, 4'b1000));
        rq[3].push_back({1'b1, 8'h3C});
        drain("tx_noack");
        chk("busy_noack", tx_busy, 1);
        exq.push_back(mk(1'b0, 4'd2, 8'h00, 4'h0));
        exq.push_back(mk(1'b0, 4'd0, 8'h00, 4'h0));
        exq.push_back(mk(1'b0, 4'd2, 8'h00, 4'h0));
        exq.push_back(mk(1'b1, 4'd2, 8'h01, 4'h0));
        rxq.push_back(8'h5A);
        pulse(1'b1, 1'b1, 8'h5A);
        drain("rx_tx_both");
        chk("busy_both", tx_busy, 0);
        auto_tx = 1'b1;

        exq.push_back(mk(1'b1, 4'd1, 8'hE0, 4'b0100));
        rq[2].push_back({1'b0, 8'hE0});
        rq[2].push_back({1'b1, 8'hE1});
        c = 0;
        while (exq.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk("mid_msg_tx", exq.size(), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_tx_busy", tx_busy, 0);
        chk("async_io", {io_write, io_read, io_addr}, 0);
        exq.delete();
        expect_boot();
        expect_tx(0, 8'hF0);
        expect_tx(2, 8'hE1);
        rq[0].push_back({1'b1, 8'hF0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drain("after_reset");
        chk("grant_after_reset", grant_id, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
